// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with memory-timeout and illegal-class traps.
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_alu_reg,
    input  logic             is_alu_imm,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic             is_lui,
    input  logic             is_auipc,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_system,
    input  logic [2:0]       funct3,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_sel,
    output logic [1:0]       wb_sel,
    output logic [1:0]       op1_sel,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] OP1_RS1  = 2'd0;
    localparam logic [1:0] OP1_PC   = 2'd1;
    localparam logic [1:0] OP1_ZERO = 2'd2;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM    = 2'd2;
    localparam logic [1:0] CAUSE_DMEM    = 2'd3;

    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam int unsigned WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    state_t            state;
    state_t            nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [3:0]        flag_cnt;
    logic              c_load;
    logic              c_store;
    logic              c_branch;
    logic              c_jump;
    logic              pc_write_q;
    logic [1:0]        pc_src_q;

    logic              n_imem_req;
    logic              n_dmem_req;
    logic              n_mem_read;
    logic              n_mem_write;
    logic              n_reg_write;
    logic              n_pc_write;
    logic [1:0]        n_pc_src;
    logic              n_alu_src;
    logic [1:0]        n_alu_op;
    logic [2:0]        n_imm_sel;
    logic [1:0]        n_wb_sel;
    logic [1:0]        n_op1_sel;
    logic              n_halted;
    logic              n_trap;
    logic [1:0]        n_cause;

    always_comb begin
        flag_cnt = 4'(is_alu_reg) + 4'(is_alu_imm) + 4'(is_branch) + 4'(is_jal)
                 + 4'(is_jalr) + 4'(is_lui) + 4'(is_auipc) + 4'(is_load)
                 + 4'(is_store) + 4'(is_system);

        nxt     = state;
        n_cause = trap_cause;
        case (state)
            S_FETCH: begin
                if (imem_ready) begin
                    nxt = S_DECODE;
                end else if (TIMEOUT_EN && wait_cnt == WAIT_LAST) begin
                    nxt     = S_TRAP;
                    n_cause = CAUSE_IMEM;
                end
            end
            S_DECODE: begin
                if (flag_cnt != 4'd1) begin
                    nxt     = S_TRAP;
                    n_cause = CAUSE_ILLEGAL;
                end else if (is_system) begin
                    nxt = S_HALT;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (c_branch || c_jump) begin
                    nxt = S_FETCH;
                end else if (c_load || c_store) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    nxt = c_load ? S_WB : S_FETCH;
                end else if (TIMEOUT_EN && wait_cnt == WAIT_LAST) begin
                    nxt     = S_TRAP;
                    n_cause = CAUSE_DMEM;
                end
            end
            S_WB:    nxt = S_FETCH;
            S_HALT:  nxt = S_HALT;
            S_TRAP:  nxt = S_TRAP;
            default: nxt = S_TRAP;
        endcase

        // Registered Moore outputs are computed for the state being entered.
        n_imem_req  = 1'b0;
        n_dmem_req  = 1'b0;
        n_mem_read  = 1'b0;
        n_mem_write = 1'b0;
        n_reg_write = 1'b0;
        n_pc_write  = 1'b0;
        n_pc_src    = 2'd0;
        n_alu_src   = 1'b0;
        n_alu_op    = 2'b00;
        n_imm_sel   = IMM_NONE;
        n_wb_sel    = WB_ALU;
        n_op1_sel   = OP1_RS1;
        case (nxt)
            S_FETCH: n_imem_req = 1'b1;
            S_EXEC: begin
                n_alu_src = 1'b1;
                if (is_alu_reg) begin
                    n_alu_src = 1'b0;
                    n_alu_op  = 2'b10;
                end else if (is_alu_imm) begin
                    n_alu_op  = (funct3 == 3'b000) ? 2'b00 : 2'b10;
                    n_imm_sel = IMM_I;
                end else if (is_load) begin
                    n_imm_sel = IMM_I;
                end else if (is_store) begin
                    n_imm_sel = IMM_S;
                end else if (is_branch) begin
                    n_alu_src  = 1'b0;
                    n_alu_op   = 2'b01;
                    n_imm_sel  = IMM_B;
                    n_pc_write = 1'b1;
                end else if (is_jal) begin
                    n_imm_sel   = IMM_J;
                    n_op1_sel   = OP1_PC;
                    n_reg_write = 1'b1;
                    n_wb_sel    = WB_PC4;
                    n_pc_write  = 1'b1;
                    n_pc_src    = 2'd1;
                end else if (is_jalr) begin
                    n_imm_sel   = IMM_I;
                    n_reg_write = 1'b1;
                    n_wb_sel    = WB_PC4;
                    n_pc_write  = 1'b1;
                    n_pc_src    = 2'd2;
                end else if (is_lui) begin
                    n_imm_sel = IMM_U;
                    n_op1_sel = OP1_ZERO;
                end else if (is_auipc) begin
                    n_imm_sel = IMM_U;
                    n_op1_sel = OP1_PC;
                end
            end
            S_MEM: begin
                n_dmem_req  = 1'b1;
                n_mem_read  = c_load;
                n_mem_write = c_store;
            end
            S_WB: begin
                n_reg_write = 1'b1;
                n_wb_sel    = c_load ? WB_MEM : WB_ALU;
                n_pc_write  = 1'b1;
            end
            default: ;
        endcase

        n_halted = halted | (nxt == S_HALT);
        n_trap   = trap | (nxt == S_TRAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset lands directly in FETCH, so the fetch request is already up.
            state      <= S_FETCH;
            wait_cnt   <= '0;
            c_load     <= 1'b0;
            c_store    <= 1'b0;
            c_branch   <= 1'b0;
            c_jump     <= 1'b0;
            imem_req   <= 1'b1;
            dmem_req   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            pc_write_q <= 1'b0;
            pc_src_q   <= 2'd0;
            alu_src    <= 1'b0;
            alu_op     <= 2'b00;
            imm_sel    <= IMM_NONE;
            wb_sel     <= WB_ALU;
            op1_sel    <= OP1_RS1;
            halted     <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
        end else begin
            state      <= nxt;
            imem_req   <= n_imem_req;
            dmem_req   <= n_dmem_req;
            mem_read   <= n_mem_read;
            mem_write  <= n_mem_write;
            reg_write  <= n_reg_write;
            pc_write_q <= n_pc_write;
            pc_src_q   <= n_pc_src;
            alu_src    <= n_alu_src;
            alu_op     <= n_alu_op;
            imm_sel    <= n_imm_sel;
            wb_sel     <= n_wb_sel;
            op1_sel    <= n_op1_sel;
            halted     <= n_halted;
            trap       <= n_trap;
            trap_cause <= n_cause;

            if (state == S_DECODE) begin
                c_load   <= is_load;
                c_store  <= is_store;
                c_branch <= is_branch;
                c_jump   <= is_jal | is_jalr;
            end

            if (nxt != state && (nxt == S_FETCH || nxt == S_MEM)) begin
                wait_cnt <= '0;
            end else if ((state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Ready-qualified strobes: the IR latch and store completion happen in the ready cycle itself.
    assign ir_write = imem_req & imem_ready;
    assign pc_write = pc_write_q | (mem_write & dmem_ready);
    assign pc_src   = (state == S_EXEC && c_branch) ? {1'b0, branch_taken} : pc_src_q;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (pc_write) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected strobes are queued per instruction
// and popped/compared each cycle; DUT built with MEM_TIMEOUT=4.
module tb_multicycle_control;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;
    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC4   = 2'd2;
    localparam logic [1:0] OP1_RS1  = 2'd0;
    localparam logic [1:0] OP1_PC   = 2'd1;
    localparam logic [1:0] OP1_ZERO = 2'd2;

    localparam int C_ALUR = 0, C_ALUI = 1, C_BR = 2, C_JAL = 3, C_JALR = 4;
    localparam int C_LUI = 5, C_AUIPC = 6, C_LOAD = 7, C_STORE = 8, C_SYS = 9, C_NONE = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr;
    logic        is_lui, is_auipc, is_load, is_store, is_system;
    logic [2:0]  funct3;
    logic        branch_taken, imem_ready, dmem_ready;
    logic        imem_req, dmem_req, mem_read, mem_write, ir_write, reg_write, pc_write;
    logic [1:0]  pc_src, alu_op, wb_sel, op1_sel, trap_cause;
    logic        alu_src, halted, trap;
    logic [2:0]  imm_sel;
    logic [31:0] cycle_cnt, instret_cnt;

    multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .is_alu_reg(is_alu_reg), .is_alu_imm(is_alu_imm), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .is_lui(is_lui), .is_auipc(is_auipc),
        .is_load(is_load), .is_store(is_store), .is_system(is_system),
        .funct3(funct3), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src(alu_src), .alu_op(alu_op), .imm_sel(imm_sel), .wb_sel(wb_sel),
        .op1_sel(op1_sel), .halted(halted), .trap(trap), .trap_cause(trap_cause),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [2:0] imm_sel;
        logic [1:0] wb_sel;
        logic [1:0] op1_sel;
        logic       halted;
        logic       trap;
        logic [1:0] trap_cause;
    } ctl_t;

    typedef struct {
        string tag;
        ctl_t  v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic ctl_t observed();
        ctl_t c;
        c.imem_req = imem_req;   c.dmem_req = dmem_req;   c.mem_read = mem_read;
        c.mem_write = mem_write; c.ir_write = ir_write;   c.reg_write = reg_write;
        c.pc_write = pc_write;   c.pc_src = pc_src;       c.alu_src = alu_src;
        c.alu_op = alu_op;       c.imm_sel = imm_sel;     c.wb_sel = wb_sel;
        c.op1_sel = op1_sel;     c.halted = halted;       c.trap = trap;
        c.trap_cause = trap_cause;
        return c;
    endfunction

    function automatic ctl_t f_fetch(input logic rdy);
        ctl_t c = '0;
        c.imem_req = 1'b1;
        c.ir_write = rdy;
        return c;
    endfunction

    function automatic ctl_t f_exec(input logic a, input logic [1:0] op, input logic [2:0] imm,
                                    input logic [1:0] o1, input logic rw, input logic [1:0] wb,
                                    input logic pw, input logic [1:0] ps);
        ctl_t c = '0;
        c.alu_src = a;    c.alu_op = op;  c.imm_sel = imm; c.op1_sel = o1;
        c.reg_write = rw; c.wb_sel = wb;  c.pc_write = pw; c.pc_src = ps;
        return c;
    endfunction

    function automatic ctl_t f_mem(input logic load, input logic rdy);
        ctl_t c = '0;
        c.dmem_req  = 1'b1;
        c.mem_read  = load;
        c.mem_write = !load;
        c.pc_write  = !load && rdy;
        return c;
    endfunction

    function automatic ctl_t f_wb(input logic load);
        ctl_t c = '0;
        c.reg_write = 1'b1;
        c.wb_sel    = load ? WB_MEM : WB_ALU;
        c.pc_write  = 1'b1;
        return c;
    endfunction

    function automatic ctl_t f_trap(input logic [1:0] cause);
        ctl_t c = '0;
        c.trap       = 1'b1;
        c.trap_cause = cause;
        return c;
    endfunction

    function automatic ctl_t f_halt();
        ctl_t c = '0;
        c.halted = 1'b1;
        return c;
    endfunction

    task automatic push(input string tag, input ctl_t v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic set_class(input int cls, input logic [2:0] f3);
        {is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr} = '0;
        {is_lui, is_auipc, is_load, is_store, is_system}     = '0;
        case (cls)
            C_ALUR:  is_alu_reg = 1'b1;
            C_ALUI:  is_alu_imm = 1'b1;
            C_BR:    is_branch  = 1'b1;
            C_JAL:   is_jal     = 1'b1;
            C_JALR:  is_jalr    = 1'b1;
            C_LUI:   is_lui     = 1'b1;
            C_AUIPC: is_auipc   = 1'b1;
            C_LOAD:  is_load    = 1'b1;
            C_STORE: is_store   = 1'b1;
            C_SYS:   is_system  = 1'b1;
            default: ;
        endcase
        funct3 = f3;
    endtask

    task automatic step();
        exp_t e;
        ctl_t obs;
        @(negedge clk);
        obs = observed();
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_underflow observed=%h expected=a queued entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp_cyc, input logic [31:0] exp_ret);
        checks++;
        assert ({cycle_cnt, instret_cnt} === {exp_cyc, exp_ret}) else begin
            failures++;
            $error("FAIL %s observed=%0d/%0d expected=%0d/%0d", tag, cycle_cnt, instret_cnt, exp_cyc, exp_ret);
        end
    endtask

    task automatic reset_cycle(input string tag, input ctl_t during);
        rst = 1'b1;
        push(tag, during);
        step();
        rst = 1'b0;
        chk_cnt({tag, "_cnt"}, 32'd0, 32'd0);
    endtask

    initial begin
        set_class(C_NONE, 3'b000);
        branch_taken = 1'b0;
        imem_ready   = 1'b1;
        dmem_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cnt("reset_cnt", 32'd0, 32'd0);

        // ADDI x1,x2,5
        set_class(C_ALUI, 3'b000);
        push("addi_fetch", f_fetch(1'b1));
        push("addi_dec", '0);
        push("addi_exec", f_exec(1'b1, 2'b00, IMM_I, OP1_RS1, 1'b0, WB_ALU, 1'b0, 2'd0));
        push("addi_wb", f_wb(1'b0));
        repeat (4) step();

        // SLTI (funct3 != 0 needs funct decode)
        set_class(C_ALUI, 3'b010);
        push("slti_fetch", f_fetch(1'b1));
        push("slti_dec", '0);
        push("slti_exec", f_exec(1'b1, 2'b10, IMM_I, OP1_RS1, 1'b0, WB_ALU, 1'b0, 2'd0));
        push("slti_wb", f_wb(1'b0));
        repeat (4) step();

        // ADD (R-type)
        set_class(C_ALUR, 3'b000);
        push("add_fetch", f_fetch(1'b1));
        push("add_dec", '0);
        push("add_exec", f_exec(1'b0, 2'b10, IMM_NONE, OP1_RS1, 1'b0, WB_ALU, 1'b0, 2'd0));
        push("add_wb", f_wb(1'b0));
        repeat (4) step();

        // LW with dmem_ready low for 3 cycles
        set_class(C_LOAD, 3'b010);
        push("lw_fetch", f_fetch(1'b1));
        push("lw_dec", '0);
        push("lw_exec", f_exec(1'b1, 2'b00, IMM_I, OP1_RS1, 1'b0, WB_ALU, 1'b0, 2'd0));
        for (int i = 0; i < 3; i++) push("lw_mem_wait", f_mem(1'b1, 1'b0));
        push("lw_mem_done", f_mem(1'b1, 1'b1));
        push("lw_wb", f_wb(1'b1));
        repeat (3) step();
        dmem_ready = 1'b0;
        repeat (3) step();
        dmem_ready = 1'b1;
        repeat (2) step();

        // SW, zero-wait
        set_class(C_STORE, 3'b010);
        push("sw_fetch", f_fetch(1'b1));
        push("sw_dec", '0);
        push("sw_exec", f_exec(1'b1, 2'b00, IMM_S, OP1_RS1, 1'b0, WB_ALU, 1'b0, 2'd0));
        push("sw_mem", f_mem(1'b0, 1'b1));
        repeat (4) step();

        // BEQ taken, then not taken
        set_class(C_BR, 3'b000);
        branch_taken = 1'b1;
        push("beq_t_fetch", f_fetch(1'b1));
        push("beq_t_dec", '0);
        push("beq_t_exec", f_exec(1'b0, 2'b01, IMM_B, OP1_RS1, 1'b0, WB_ALU, 1'b1, 2'd1));
        repeat (3) step();
        branch_taken = 1'b0;
        push("beq_n_fetch", f_fetch(1'b1));
        push("beq_n_dec", '0);
        push("beq_n_exec", f_exec(1'b0, 2'b01, IMM_B, OP1_RS1, 1'b0, WB_ALU, 1'b1, 2'd0));
        repeat (3) step();

        // JAL, JALR
        set_class(C_JAL, 3'b000);
        push("jal_fetch", f_fetch(1'b1));
        push("jal_dec", '0);
        push("jal_exec", f_exec(1'b1, 2'b00, IMM_J, OP1_PC, 1'b1, WB_PC4, 1'b1, 2'd1));
        repeat (3) step();
        set_class(C_JALR, 3'b000);
        push("jalr_fetch", f_fetch(1'b1));
        push("jalr_dec", '0);
        push("jalr_exec", f_exec(1'b1, 2'b00, IMM_I, OP1_RS1, 1'b1, WB_PC4, 1'b1, 2'd2));
        repeat (3) step();

        // LUI, AUIPC
        set_class(C_LUI, 3'b000);
        push("lui_fetch", f_fetch(1'b1));
        push("lui_dec", '0);
        push("lui_exec", f_exec(1'b1, 2'b00, IMM_U, OP1_ZERO, 1'b0, WB_ALU, 1'b0, 2'd0));
        push("lui_wb", f_wb(1'b0));
        repeat (4) step();
        set_class(C_AUIPC, 3'b000);
        push("auipc_fetch", f_fetch(1'b1));
        push("auipc_dec", '0);
        push("auipc_exec", f_exec(1'b1, 2'b00, IMM_U, OP1_PC, 1'b0, WB_ALU, 1'b0, 2'd0));
        push("auipc_wb", f_wb(1'b0));
        repeat (4) step();

        // imem_ready arrives on the timeout cycle: ready wins
        set_class(C_ALUI, 3'b000);
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) push("late_fetch_wait", f_fetch(1'b0));
        push("late_fetch_ready", f_fetch(1'b1));
        push("late_dec", '0);
        push("late_exec", f_exec(1'b1, 2'b00, IMM_I, OP1_RS1, 1'b0, WB_ALU, 1'b0, 2'd0));
        push("late_wb", f_wb(1'b0));
        repeat (3) step();
        imem_ready = 1'b1;
        repeat (4) step();

        // rst asserted mid-MEM
        set_class(C_LOAD, 3'b010);
        push("rstmem_fetch", f_fetch(1'b1));
        push("rstmem_dec", '0);
        push("rstmem_exec", f_exec(1'b1, 2'b00, IMM_I, OP1_RS1, 1'b0, WB_ALU, 1'b0, 2'd0));
        repeat (3) step();
        dmem_ready = 1'b0;
        reset_cycle("rstmem_mem", f_mem(1'b1, 1'b0));
        dmem_ready = 1'b1;
        set_class(C_ALUR, 3'b000);
        push("post_rst_fetch", f_fetch(1'b1));
        push("post_rst_dec", '0);
        push("post_rst_exec", f_exec(1'b0, 2'b10, IMM_NONE, OP1_RS1, 1'b0, WB_ALU, 1'b0, 2'd0));
        push("post_rst_wb", f_wb(1'b0));
        repeat (4) step();

        // No class flag -> illegal trap, sticky
        set_class(C_NONE, 3'b000);
        push("ill0_fetch", f_fetch(1'b1));
        push("ill0_dec", '0);
        push("ill0_trap", f_trap(2'd1));
        push("ill0_trap_sticky", f_trap(2'd1));
        repeat (4) step();
        reset_cycle("ill0_rst", f_trap(2'd1));

        // Two class flags -> illegal trap
        set_class(C_LOAD, 3'b000);
        is_store = 1'b1;
        push("ill2_fetch", f_fetch(1'b1));
        push("ill2_dec", '0);
        push("ill2_trap", f_trap(2'd1));
        repeat (3) step();
        reset_cycle("ill2_rst", f_trap(2'd1));

        // SYSTEM -> halt, no further fetch
        set_class(C_SYS, 3'b000);
        push("sys_fetch", f_fetch(1'b1));
        push("sys_dec", '0);
        for (int i = 0; i < 3; i++) push("sys_halt", f_halt());
        repeat (5) step();
        reset_cycle("sys_rst", f_halt());

        // imem timeout
        set_class(C_ALUR, 3'b000);
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) push("itmo_fetch", f_fetch(1'b0));
        push("itmo_trap", f_trap(2'd2));
        push("itmo_trap_sticky", f_trap(2'd2));
        repeat (6) step();
        reset_cycle("itmo_rst", f_trap(2'd2));
        imem_ready = 1'b1;

        // dmem timeout
        set_class(C_LOAD, 3'b010);
        push("dtmo_fetch", f_fetch(1'b1));
        push("dtmo_dec", '0);
        push("dtmo_exec", f_exec(1'b1, 2'b00, IMM_I, OP1_RS1, 1'b0, WB_ALU, 1'b0, 2'd0));
        for (int i = 0; i < 4; i++) push("dtmo_mem", f_mem(1'b1, 1'b0));
        push("dtmo_trap", f_trap(2'd3));
        push("dtmo_trap_sticky", f_trap(2'd3));
        repeat (3) step();
        dmem_ready = 1'b0;
        repeat (6) step();
        reset_cycle("dtmo_rst", f_trap(2'd3));
        dmem_ready = 1'b1;

        // One retired ADDI after reset, then counters
        set_class(C_ALUI, 3'b000);
        push("final_fetch", f_fetch(1'b1));
        push("final_dec", '0);
        push("final_exec", f_exec(1'b1, 2'b00, IMM_I, OP1_RS1, 1'b0, WB_ALU, 1'b0, 2'd0));
        push("final_wb", f_wb(1'b0));
        repeat (4) step();
`ifdef CTRL_PERF_CNT_EN
        chk_cnt("final_cnt", 32'd4, 32'd1);
`else
        chk_cnt("final_cnt", 32'd0, 32'd0);
`endif

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
